// File: rtl/lsu.sv
// Load/store unit: one data-bus transaction per instruction, with alignment check,
// lane steering, load extension and a bus timeout; non-memory results pass through.
module lsu #(
   parameter int unsigned BUS_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        exu_data_ok,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [1:0]  mem_size,
   input  logic        mem_unsigned,
   input  logic [63:0] addr,
   input  logic [63:0] wdata,
   output logic        dreq_valid,
   output logic [63:0] dreq_addr,
   output logic        dreq_wr,
   output logic [7:0]  dreq_strobe,
   output logic [63:0] dreq_wdata,
   input  logic        dresp_data_ok,
   input  logic [63:0] dresp_data,
   output logic        lsu_data_ok,
   output logic [63:0] lsu_result,
   output logic        lsu_misalign,
   output logic        lsu_bus_err,
   output logic        lsu_busy
);

   localparam logic [7:0] LP_TIMEOUT = 8'(BUS_TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      r_state, w_state_nxt;
   logic        r_valid, w_valid_nxt;
   logic [63:0] r_addr, w_addr_nxt;
   logic        r_wr, w_wr_nxt;
   logic [7:0]  r_strobe, w_strobe_nxt;
   logic [63:0] r_wdata, w_wdata_nxt;
   logic [1:0]  r_size, w_size_nxt;
   logic        r_unsigned, w_unsigned_nxt;
   logic [7:0]  r_cnt, w_cnt_nxt;
   logic [63:0] r_result, w_result_nxt;
   logic        r_data_ok, w_data_ok_nxt;
   logic        r_misalign, w_misalign_nxt;
   logic        r_bus_err, w_bus_err_nxt;
   logic        r_busy, w_busy_nxt;

   function automatic logic f_misaligned(input logic [2:0] ofs, input logic [1:0] size);
      case (size)
         2'd0:    f_misaligned = 1'b0;
         2'd1:    f_misaligned = ofs[0];
         2'd2:    f_misaligned = |ofs[1:0];
         default: f_misaligned = |ofs;
      endcase
   endfunction

   function automatic logic [7:0] f_strobe(input logic [2:0] ofs, input logic [1:0] size);
      logic [7:0] base;
      case (size)
         2'd0:    base = 8'h01;
         2'd1:    base = 8'h03;
         2'd2:    base = 8'h0F;
         default: base = 8'hFF;
      endcase
      f_strobe = base << ofs;
   endfunction

   function automatic logic [63:0] f_load(input logic [63:0] data, input logic [2:0] ofs,
                                          input logic [1:0] size, input logic uns);
      logic [63:0] sh;
      sh = data >> {ofs, 3'b000};
      case (size)
         2'd0:    f_load = uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
         2'd1:    f_load = uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
         2'd2:    f_load = uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
         default: f_load = sh;
      endcase
   endfunction

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      w_state_nxt    = r_state;
      w_valid_nxt    = r_valid;
      w_addr_nxt     = r_addr;
      w_wr_nxt       = r_wr;
      w_strobe_nxt   = r_strobe;
      w_wdata_nxt    = r_wdata;
      w_size_nxt     = r_size;
      w_unsigned_nxt = r_unsigned;
      w_cnt_nxt      = r_cnt;
      w_result_nxt   = r_result;
      w_data_ok_nxt  = 1'b0;
      w_misalign_nxt = 1'b0;
      w_bus_err_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (exu_data_ok) begin
               if (!mem_rd && !mem_wr) begin
                  w_result_nxt  = addr;
                  w_data_ok_nxt = 1'b1;
                  w_state_nxt   = ST_DONE;
               end else if (f_misaligned(addr[2:0], mem_size)) begin
                  w_result_nxt   = 64'd0;
                  w_misalign_nxt = 1'b1;
                  w_data_ok_nxt  = 1'b1;
                  w_state_nxt    = ST_DONE;
               end else begin
                  w_addr_nxt     = addr;
                  w_wr_nxt       = mem_wr;
                  w_strobe_nxt   = mem_wr ? f_strobe(addr[2:0], mem_size) : 8'hFF;
                  w_wdata_nxt    = wdata << {addr[2:0], 3'b000};
                  w_size_nxt     = mem_size;
                  w_unsigned_nxt = mem_unsigned;
                  w_cnt_nxt      = 8'd0;
                  w_valid_nxt    = 1'b1;
                  w_state_nxt    = ST_REQ;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_REQ: begin
            // A response in the same cycle the counter expires still wins.
            if (dresp_data_ok) begin
               w_valid_nxt   = 1'b0;
               w_data_ok_nxt = 1'b1;
               w_result_nxt  = r_wr ? 64'd0 : f_load(dresp_data, r_addr[2:0], r_size, r_unsigned);
               w_state_nxt   = ST_DONE;
            end else if ((r_cnt + 8'd1) == LP_TIMEOUT) begin
               w_cnt_nxt     = r_cnt + 8'd1;
               w_valid_nxt   = 1'b0;
               w_data_ok_nxt = 1'b1;
               w_bus_err_nxt = 1'b1;
               w_result_nxt  = 64'd0;
               w_state_nxt   = ST_DONE;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
         end
      endcase
      w_busy_nxt = (w_state_nxt != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_valid    <= 1'b0;
         r_addr     <= 64'd0;
         r_wr       <= 1'b0;
         r_strobe   <= 8'd0;
         r_wdata    <= 64'd0;
         r_size     <= 2'd0;
         r_unsigned <= 1'b0;
         r_cnt      <= 8'd0;
         r_result   <= 64'd0;
         r_data_ok  <= 1'b0;
         r_misalign <= 1'b0;
         r_bus_err  <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_valid    <= w_valid_nxt;
         r_addr     <= w_addr_nxt;
         r_wr       <= w_wr_nxt;
         r_strobe   <= w_strobe_nxt;
         r_wdata    <= w_wdata_nxt;
         r_size     <= w_size_nxt;
         r_unsigned <= w_unsigned_nxt;
         r_cnt      <= w_cnt_nxt;
         r_result   <= w_result_nxt;
         r_data_ok  <= w_data_ok_nxt;
         r_misalign <= w_misalign_nxt;
         r_bus_err  <= w_bus_err_nxt;
         r_busy     <= w_busy_nxt;
      end
   end

   assign dreq_valid   = r_valid;
   assign dreq_addr    = r_addr;
   assign dreq_wr      = r_wr;
   assign dreq_strobe  = r_strobe;
   assign dreq_wdata   = r_wdata;
   assign lsu_data_ok  = r_data_ok;
   assign lsu_result   = r_result;
   assign lsu_misalign = r_misalign;
   assign lsu_bus_err  = r_bus_err;
   assign lsu_busy     = r_busy;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed cases plus randomized transactions checked against an
// arithmetic reference model of alignment, lane steering and load extension.
module tb_lsu;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        exu_data_ok;
   logic        mem_rd;
   logic        mem_wr;
   logic [1:0]  mem_size;
   logic        mem_unsigned;
   logic [63:0] addr;
   logic [63:0] wdata;
   logic        dreq_valid;
   logic [63:0] dreq_addr;
   logic        dreq_wr;
   logic [7:0]  dreq_strobe;
   logic [63:0] dreq_wdata;
   logic        dresp_data_ok;
   logic [63:0] dresp_data;
   logic        lsu_data_ok;
   logic [63:0] lsu_result;
   logic        lsu_misalign;
   logic        lsu_bus_err;
   logic        lsu_busy;

   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] exp_last = 64'd0;

   lsu #(.BUS_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .exu_data_ok(exu_data_ok), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_size(mem_size), .mem_unsigned(mem_unsigned), .addr(addr), .wdata(wdata),
      .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_wr(dreq_wr),
      .dreq_strobe(dreq_strobe), .dreq_wdata(dreq_wdata), .dresp_data_ok(dresp_data_ok),
      .dresp_data(dresp_data), .lsu_data_ok(lsu_data_ok), .lsu_result(lsu_result),
      .lsu_misalign(lsu_misalign), .lsu_bus_err(lsu_bus_err), .lsu_busy(lsu_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Garbage on the request inputs while the unit must ignore them.
   task automatic scramble;
      mem_rd       = 1'($urandom_range(0, 1));
      mem_wr       = ~mem_rd & 1'($urandom_range(0, 1));
      mem_size     = 2'($urandom_range(0, 3));
      mem_unsigned = 1'($urandom_range(0, 1));
      addr         = rnd64();
      wdata        = rnd64();
   endtask

   task automatic run_txn(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [63:0] a, input logic [63:0] wd, input int wait_n,
                          input logic [63:0] rdata);
      int          bytes;
      int          ofs;
      int          n_valid;
      logic        mis;
      logic        timed_out;
      logic [63:0] sh;
      logic [63:0] mask;
      logic [63:0] exp_res;
      logic [63:0] exp_strb;
      bytes = 1 << sz;
      ofs   = int'(a[2:0]);
      mis   = (rd | wr) && ((a & 64'(bytes - 1)) != 64'd0);
      exu_data_ok = 1'b1; mem_rd = rd; mem_wr = wr; mem_size = sz; mem_unsigned = uns;
      addr = a; wdata = wd;
      tick;
      exu_data_ok = 1'b0;
      scramble();
      if (!(rd | wr) || mis) begin
         exp_last = mis ? 64'd0 : a;
         chk("imm_dreq_valid", dreq_valid, 64'd0);
         chk("imm_data_ok", lsu_data_ok, 64'd1);
         chk("imm_result", lsu_result, exp_last);
         chk("imm_misalign", lsu_misalign, 64'(mis));
         chk("imm_bus_err", lsu_bus_err, 64'd0);
         chk("imm_busy", lsu_busy, 64'd1);
      end else begin
         timed_out = (wait_n >= TMO);
         n_valid   = timed_out ? TMO : wait_n + 1;
         exp_strb  = wr ? 64'((((1 << bytes) - 1) << ofs) & 255) : 64'hFF;
         for (int c = 0; c < n_valid; c++) begin
            chk("req_valid", dreq_valid, 64'd1);
            chk("req_addr", dreq_addr, a);
            chk("req_wr", dreq_wr, 64'(wr));
            chk("req_strobe", dreq_strobe, exp_strb);
            chk("req_wdata", dreq_wdata, wd << (8 * ofs));
            chk("req_data_ok", lsu_data_ok, 64'd0);
            chk("req_busy", lsu_busy, 64'd1);
            if (c == 1 || $urandom_range(0, 3) == 0) begin
               exu_data_ok = 1'b1;
               scramble();
            end
            if (c == wait_n) begin
               dresp_data_ok = 1'b1;
               dresp_data    = rdata;
            end
            tick;
            exu_data_ok   = 1'b0;
            dresp_data_ok = 1'b0;
            dresp_data    = rnd64();
         end
         if (timed_out || wr) begin
            exp_res = 64'd0;
         end else begin
            sh = rdata >> (8 * ofs);
            if (bytes == 8) begin
               exp_res = sh;
            end else begin
               mask    = (64'd1 << (8 * bytes)) - 64'd1;
               exp_res = sh & mask;
               if (!uns && sh[8 * bytes - 1]) exp_res = exp_res | ~mask;
            end
         end
         exp_last = exp_res;
         chk("done_data_ok", lsu_data_ok, 64'd1);
         chk("done_dreq_valid", dreq_valid, 64'd0);
         chk("done_result", lsu_result, exp_res);
         chk("done_bus_err", lsu_bus_err, 64'(timed_out));
         chk("done_misalign", lsu_misalign, 64'd0);
      end
      tick;
      chk("idle_data_ok", lsu_data_ok, 64'd0);
      chk("idle_busy", lsu_busy, 64'd0);
      chk("idle_misalign", lsu_misalign, 64'd0);
      chk("idle_bus_err", lsu_bus_err, 64'd0);
      chk("idle_result_hold", lsu_result, exp_last);
   endtask

   task automatic stray_resp;
      dresp_data_ok = 1'b1;
      dresp_data    = rnd64();
      tick;
      dresp_data_ok = 1'b0;
      chk("stray_data_ok", lsu_data_ok, 64'd0);
      chk("stray_busy", lsu_busy, 64'd0);
      chk("stray_dreq_valid", dreq_valid, 64'd0);
      chk("stray_result", lsu_result, exp_last);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic       rd;
      logic       wr;
      logic [1:0] sz;
      logic [63:0] a;
      rst = 1'b0; exu_data_ok = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; mem_size = 2'd0;
      mem_unsigned = 1'b0; addr = 64'd0; wdata = 64'd0; dresp_data_ok = 1'b0; dresp_data = 64'd0;
      tick; tick;
      chk("rst_dreq_valid", dreq_valid, 64'd0);
      chk("rst_dreq_addr", dreq_addr, 64'd0);
      chk("rst_dreq_wdata", dreq_wdata, 64'd0);
      chk("rst_dreq_strobe", dreq_strobe, 64'd0);
      chk("rst_dreq_wr", dreq_wr, 64'd0);
      chk("rst_result", lsu_result, 64'd0);
      chk("rst_flags", {lsu_data_ok, lsu_misalign, lsu_bus_err, lsu_busy}, 64'd0);
      rst = 1'b1;
      tick;

      run_txn(1'b0, 1'b0, 2'd0, 1'b0, 64'h1234, 64'd0, 0, 64'd0);
      run_txn(1'b1, 1'b0, 2'd0, 1'b0, 64'h1003, 64'd0, 0, 64'h0000_0000_8000_0000);
      run_txn(1'b0, 1'b1, 2'd1, 1'b0, 64'h2006, 64'hABCD, 3, 64'd0);
      run_txn(1'b1, 1'b0, 2'd2, 1'b0, 64'h3002, 64'd0, 0, 64'd0);
      run_txn(1'b1, 1'b0, 2'd3, 1'b0, 64'h4000, 64'd0, 99, 64'd0);
      run_txn(1'b1, 1'b0, 2'd2, 1'b0, 64'h5004, 64'd0, TMO - 1, 64'hDEAD_BEEF_0000_0000);
      stray_resp();

      // Reset in the middle of a request, with a late response.
      exu_data_ok = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; mem_size = 2'd3; addr = 64'h40;
      tick;
      exu_data_ok = 1'b0;
      chk("mid_valid", dreq_valid, 64'd1);
      tick;
      rst = 1'b0;
      #1;
      chk("async_drop_valid", dreq_valid, 64'd0);
      chk("async_drop_busy", lsu_busy, 64'd0);
      dresp_data_ok = 1'b1; dresp_data = 64'h1111;
      tick;
      dresp_data_ok = 1'b0;
      rst = 1'b1;
      tick;
      exp_last = 64'd0;
      chk("post_rst_data_ok", lsu_data_ok, 64'd0);
      chk("post_rst_result", lsu_result, 64'd0);
      run_txn(1'b1, 1'b0, 2'd1, 1'b1, 64'h6002, 64'd0, 1, 64'h0000_0000_F00D_0000);

      for (int i = 0; i < 300; i++) begin
         rd = 1'b0; wr = 1'b0;
         case ($urandom_range(0, 4))
            0:       begin rd = 1'b0; wr = 1'b0; end
            1, 2:    rd = 1'b1;
            default: wr = 1'b1;
         endcase
         sz = 2'($urandom_range(0, 3));
         a  = rnd64();
         if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << sz) - 1);
         run_txn(rd, wr, sz, 1'($urandom_range(0, 1)), a, rnd64(),
                 int'($urandom_range(0, TMO + 1)), rnd64());
         if ($urandom_range(0, 7) == 0) stray_resp();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
